// File: rtl/poly_mult_accum_seq_pkg.sv
// Shared FSM encoding and seed-mode constants for the polynomial multiply-accumulate sequencer.
package poly_acc_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_MUL  = 3'd2,
        S_ACC  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic INIT_BASE = 1'b0;
    localparam logic INIT_ZERO = 1'b1;

endpackage

// File: rtl/poly_mult_accum_seq_if.sv
// Memory-side buses of the sequencer: base vector read, external multiplier handshake/readout, result readout.
interface poly_mult_accum_seq_if #(
    parameter int unsigned RAMWIDTH = 128,
    parameter int unsigned AW       = 8,
    parameter int unsigned SEL_W    = 1
) ();

    logic                base_rd_en;
    logic [AW-1:0]       base_addr;
    logic [RAMWIDTH-1:0] base_din;

    logic                pm_start;
    logic [SEL_W-1:0]    pm_sel;
    logic                pm_valid;
    logic                pm_rd_dout;
    logic [AW-1:0]       pm_addr_result;
    logic [RAMWIDTH-1:0] pm_dout;

    logic                out_en;
    logic [AW-1:0]       out_addr;
    logic [RAMWIDTH-1:0] out_data;

    modport master (
        output base_rd_en, base_addr,
        input  base_din,
        output pm_start, pm_sel,
        input  pm_valid,
        output pm_rd_dout, pm_addr_result,
        input  pm_dout,
        input  out_en, out_addr,
        output out_data
    );

    modport slave (
        input  base_rd_en, base_addr,
        output base_din,
        input  pm_start, pm_sel,
        output pm_valid,
        input  pm_rd_dout, pm_addr_result,
        output pm_dout,
        output out_en, out_addr,
        input  out_data
    );

endinterface

// File: rtl/poly_mult_accum_seq_acc_ram.sv
// Accumulator storage: simple dual-port RAM, one write port and one registered read port.
module acc_ram #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/poly_mult_accum_seq.sv
// Sequencer accumulating seed XOR a series of externally computed sparse x dense products into acc_ram.
// Optional build macro POLY_ACC_TAIL_MASK_EN clears unused bits of the last accumulator word on every write.
module poly_mult_accum_seq
    import poly_acc_pkg::*;
#(
    parameter int unsigned RAMWIDTH  = 128,
    parameter int unsigned N         = 17669,
    parameter int unsigned RAMDEPTH  = (N + RAMWIDTH - 1) / RAMWIDTH,
    parameter int unsigned NUM_TERMS = 2,
    localparam int unsigned LOG_RAMDEPTH = $clog2(RAMDEPTH),
    localparam int unsigned LOG_TERMS    = $clog2(NUM_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 init_mode,
    input  logic [LOG_TERMS-1:0] num_terms,
    output logic                 busy,
    output logic                 done,
    poly_mult_accum_seq_if.master bus
);

    localparam int unsigned AW    = (LOG_RAMDEPTH > 0) ? LOG_RAMDEPTH : 1;
    localparam int unsigned SEL_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int unsigned CW    = $clog2(RAMDEPTH + 1);

    state_t               state, state_d;
    logic                 mode_q, mode_d;
    logic [LOG_TERMS-1:0] terms_q, terms_d;
    logic [LOG_TERMS-1:0] term_q, term_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_word;
    logic                 issue;

    logic                 busy_nx, done_nx, pm_start_nx, base_rd_en_nx, pm_rd_nx;
    logic [AW-1:0]        base_addr_nx, pm_addr_nx;
    logic [SEL_W-1:0]     pm_sel_nx;
    logic                 out_vld;

    logic                 ram_wr_en, ram_rd_en;
    logic [AW-1:0]        ram_wr_addr, ram_rd_addr;
    logic [RAMWIDTH-1:0]  ram_wr_data, ram_wr_data_m, ram_rd_data;

    assign last_word = (cnt_q == CW'(RAMDEPTH));

    // Next state plus next values of every registered output
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        terms_d = terms_q;
        term_d  = term_q;
        cnt_d   = cnt_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_d  = init_mode;
                    terms_d = (num_terms > LOG_TERMS'(NUM_TERMS)) ? LOG_TERMS'(NUM_TERMS) : num_terms;
                    term_d  = '0;
                    cnt_d   = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (last_word) begin
                    cnt_d   = '0;
                    state_d = (terms_q == '0) ? S_DONE : S_MUL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MUL: begin
                if (bus.pm_valid) begin
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (last_word) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                term_d  = term_q + LOG_TERMS'(1);
                state_d = (term_d < terms_q) ? S_MUL : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        issue         = (cnt_d < CW'(RAMDEPTH));
        busy_nx       = (state_d != S_IDLE);
        done_nx       = (state_d == S_DONE);
        pm_start_nx   = (state_d == S_MUL) && (state != S_MUL);
        pm_sel_nx     = SEL_W'(term_d);
        base_rd_en_nx = (state_d == S_INIT) && issue && (mode_d == INIT_BASE);
        base_addr_nx  = ((state_d == S_INIT) && issue) ? AW'(cnt_d) : '0;
        pm_rd_nx      = (state_d == S_ACC) && issue;
        pm_addr_nx    = pm_rd_nx ? AW'(cnt_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            mode_q             <= INIT_BASE;
            terms_q            <= '0;
            term_q             <= '0;
            cnt_q              <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            bus.pm_start       <= 1'b0;
            bus.pm_sel         <= '0;
            bus.base_rd_en     <= 1'b0;
            bus.base_addr      <= '0;
            bus.pm_rd_dout     <= 1'b0;
            bus.pm_addr_result <= '0;
            out_vld            <= 1'b0;
        end else begin
            state              <= state_d;
            mode_q             <= mode_d;
            terms_q            <= terms_d;
            term_q             <= term_d;
            cnt_q              <= cnt_d;
            busy               <= busy_nx;
            done               <= done_nx;
            bus.pm_start       <= pm_start_nx;
            bus.pm_sel         <= pm_sel_nx;
            bus.base_rd_en     <= base_rd_en_nx;
            bus.base_addr      <= base_addr_nx;
            bus.pm_rd_dout     <= pm_rd_nx;
            bus.pm_addr_result <= pm_addr_nx;
            out_vld            <= (state == S_IDLE) && bus.out_en;
        end
    end

    // Word a is read (base or acc) at count a and written back at count a+1
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = AW'(cnt_q - CW'(1));
        ram_wr_data = '0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = bus.out_addr;
        case (state)
            S_INIT: begin
                ram_wr_en   = (cnt_q != '0);
                ram_wr_data = (mode_q == INIT_ZERO) ? '0 : bus.base_din;
            end
            S_ACC: begin
                ram_wr_en   = (cnt_q != '0);
                ram_wr_data = bus.pm_dout ^ ram_rd_data;
                ram_rd_en   = !last_word;
                ram_rd_addr = AW'(cnt_q);
            end
            S_IDLE:  ram_rd_en = bus.out_en;
            default: ;
        endcase
    end

`ifdef POLY_ACC_TAIL_MASK_EN
    localparam int unsigned TAIL_BITS = N - RAMWIDTH * (RAMDEPTH - 1);
    localparam logic [RAMWIDTH-1:0] TAIL_MASK = {RAMWIDTH{1'b1}} >> (RAMWIDTH - TAIL_BITS);

    always_comb begin
        ram_wr_data_m = ram_wr_data;
        if (ram_wr_addr == AW'(RAMDEPTH - 1)) begin
            ram_wr_data_m = ram_wr_data & TAIL_MASK;
        end
    end
`else
    assign ram_wr_data_m = ram_wr_data;
`endif

    acc_ram #(
        .WIDTH (RAMWIDTH),
        .DEPTH (RAMDEPTH),
        .AW    (AW)
    ) u_acc_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data_m),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // RAM read data is only visible for reads accepted while idle
    assign bus.out_data = out_vld ? ram_rd_data : '0;

endmodule
